// File: rtl/stream_ser_tx_if.sv
// Valid/accept bundle between a packet requester, the serialiser and the beat sink.
// The slave modport is the serialiser's view; master is the surrounding logic.
interface stream_ser_tx_if #(
    parameter int W = 32,
    parameter int N = 4
);
    localparam int LW = $clog2(N);

    logic           in_vld;
    logic [N*W-1:0] in_data;
    logic [LW-1:0]  in_len;
    logic           in_accept;
    logic           out_accept;
    logic           out_vld_r;
    logic [W-1:0]   out_r;
    logic           out_last_r;
    logic           stall_req;

    modport slave (
        input  in_vld,
        input  in_data,
        input  in_len,
        output in_accept,
        input  out_accept,
        output out_vld_r,
        output out_r,
        output out_last_r,
        input  stall_req
    );

    modport master (
        output in_vld,
        output in_data,
        output in_len,
        input  in_accept,
        output out_accept,
        input  out_vld_r,
        input  out_r,
        input  out_last_r,
        output stall_req
    );
endinterface

// File: rtl/stream_ser_tx.sv
// Serialises an N-word packet into W-bit beats with a last flag.
// Define STREAM_SER_TX_STATS_EN to add beat and packet counters.
module stream_ser_tx #(
    parameter int W = 32,
    parameter int N = 4,
    localparam int LW = $clog2(N)
) (
    input logic clk,
    input logic rst,
    stream_ser_tx_if.slave bus
`ifdef STREAM_SER_TX_STATS_EN
    ,
    output logic [31:0] beats_sent_r,
    output logic [31:0] pkts_sent_r
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N*W-1:0] sh_q;
    logic [W-1:0]   out_q;
    logic [LW-1:0]  rem_q;
    logic           last_q;

    logic in_acc;
    logic in_adv;
    logic out_adv;
    logic done;
    logic load;
    logic shift;
    logic go_idle;

    assign out_adv = (state_q == SEND) & bus.out_accept;
    assign done    = out_adv & (rem_q == '0);
    assign in_adv  = bus.in_vld & in_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (in_adv) state_d = SEND;
            end
            (state_q == SEND): begin
                if (done & ~in_adv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new packet may only replace the one on the wire as its last beat leaves.
    always_comb begin
        in_acc  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        go_idle = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                in_acc = ~bus.stall_req;
                load   = bus.in_vld & ~bus.stall_req;
            end
            (state_q == SEND): begin
                in_acc  = ~bus.stall_req & last_q & bus.out_accept;
                load    = bus.in_vld & in_acc;
                shift   = out_adv & (rem_q != '0);
                go_idle = done & ~(bus.in_vld & in_acc);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            last_q <= 1'b0;
        end else if (load) begin
            rem_q  <= bus.in_len;
            last_q <= (bus.in_len == '0);
        end else if (shift) begin
            rem_q  <= rem_q - LW'(1);
            last_q <= (rem_q == LW'(1));
        end else if (go_idle) begin
            last_q <= 1'b0;
        end
    end

    // Payload is not reset; out_vld_r qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            sh_q  <= bus.in_data;
            out_q <= bus.in_data[W-1:0];
        end else if (shift) begin
            sh_q  <= sh_q >> W;
            out_q <= sh_q[W +: W];
        end
    end

    assign bus.in_accept  = in_acc;
    assign bus.out_vld_r  = (state_q == SEND);
    assign bus.out_r      = out_q;
    assign bus.out_last_r = last_q;

`ifdef STREAM_SER_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_sent_r <= '0;
            pkts_sent_r  <= '0;
        end else if (out_adv) begin
            beats_sent_r <= beats_sent_r + 32'd1;
            if (last_q) pkts_sent_r <= pkts_sent_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_ser_tx.sv
// Bench for stream_ser_tx: fixed vector table, corner sequences and
// random traffic against a beat-queue reference model.
module tb_stream_ser_tx;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int LW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_ser_tx_if #(.W(W), .N(N)) bus ();

`ifdef STREAM_SER_TX_STATS_EN
    logic [31:0] beats_sent_r;
    logic [31:0] pkts_sent_r;
    int unsigned mb;
    int unsigned mp;
`endif

    stream_ser_tx #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STREAM_SER_TX_STATS_EN
        ,
        .beats_sent_r (beats_sent_r),
        .pkts_sent_r  (pkts_sent_r)
`endif
    );

    typedef struct {
        logic           vld;
        logic [N*W-1:0] data;
        logic [LW-1:0]  len;
        logic           oacc;
        logic           stall;
        logic           e_vld;
        logic [W-1:0]   e_data;
        logic           e_last;
        logic           e_iacc;
    } vec_t;

    vec_t tbl[18];

    logic [W-1:0] qd[$];
    bit           ql[$];
    bit           took;
    int           tests = 0;
    int           fails = 0;

    function automatic vec_t mk(logic v, logic [N*W-1:0] d, logic [LW-1:0] l,
                                logic oa, logic st, logic ev, logic [W-1:0] ed,
                                logic el, logic ei);
        vec_t r;
        r.vld = v; r.data = d; r.len = l; r.oacc = oa; r.stall = st;
        r.e_vld = ev; r.e_data = ed; r.e_last = el; r.e_iacc = ei;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model check at the negedge, then apply the coming edge to the model.
    task automatic step();
        bit acc_exp;
        acc_exp = !bus.stall_req &&
                  (qd.size() == 0 || (qd.size() == 1 && bus.out_accept));
        chk("in_accept", {31'd0, bus.in_accept}, {31'd0, acc_exp});
        chk("out_vld", {31'd0, bus.out_vld_r}, {31'd0, qd.size() != 0});
        if (qd.size() != 0) begin
            chk("out_r", {24'd0, bus.out_r}, {24'd0, qd[0]});
            chk("out_last", {31'd0, bus.out_last_r}, {31'd0, ql[0]});
        end else begin
            chk("out_last_idle", {31'd0, bus.out_last_r}, 32'd0);
        end
`ifdef STREAM_SER_TX_STATS_EN
        chk("beats_sent", beats_sent_r, mb);
        chk("pkts_sent", pkts_sent_r, mp);
`endif
        took = bus.in_vld && acc_exp;
        if (rst) begin
            qd.delete();
            ql.delete();
`ifdef STREAM_SER_TX_STATS_EN
            mb = 0;
            mp = 0;
`endif
        end else begin
            if (qd.size() != 0 && bus.out_accept) begin
`ifdef STREAM_SER_TX_STATS_EN
                mb++;
                if (ql[0]) mp++;
`endif
                void'(qd.pop_front());
                void'(ql.pop_front());
            end
            if (took) begin
                for (int k = 0; k <= int'(bus.in_len); k++) begin
                    qd.push_back(bus.in_data[k*W +: W]);
                    ql.push_back(k == int'(bus.in_len));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        step();
    endtask

    task automatic drive(logic v, logic [N*W-1:0] d, logic [LW-1:0] l,
                         logic oa, logic st);
        bus.in_vld     = v;
        bus.in_data    = d;
        bus.in_len     = l;
        bus.out_accept = oa;
        bus.stall_req  = st;
    endtask

    task automatic send_pkt(logic [N*W-1:0] d, logic [LW-1:0] l);
        int n;
        n = 0;
        drive(1'b1, d, l, 1'b1, 1'b0);
        took = 1'b0;
        while (!took && n < 20) begin
            cyc();
            n++;
        end
        chk("send_pkt_taken", {31'd0, took}, 32'd1);
        bus.in_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_vld", {31'd0, bus.out_vld_r}, 32'd0);
        chk("rst_out_last", {31'd0, bus.out_last_r}, 32'd0);
        chk("rst_in_accept", {31'd0, bus.in_accept}, 32'd1);
        @(posedge clk);
        #1;

        // Single 4-beat packet, back-to-back A/B, then backpressure pattern.
        tbl[0]  = mk(1, 32'h44332211, 2'd3, 1, 0, 0, 8'h00, 0, 1);
        tbl[1]  = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h11, 0, 0);
        tbl[2]  = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h22, 0, 0);
        tbl[3]  = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h33, 0, 0);
        tbl[4]  = mk(1, 32'h0000BBAA, 2'd1, 1, 0, 1, 8'h44, 1, 1);
        tbl[5]  = mk(1, 32'h000000CC, 2'd0, 1, 0, 1, 8'hAA, 0, 0);
        tbl[6]  = mk(1, 32'h000000CC, 2'd0, 1, 0, 1, 8'hBB, 1, 1);
        tbl[7]  = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'hCC, 1, 1);
        tbl[8]  = mk(0, 32'h0,        2'd0, 0, 0, 0, 8'h00, 0, 1);
        tbl[9]  = mk(1, 32'h44332211, 2'd3, 1, 0, 0, 8'h00, 0, 1);
        tbl[10] = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h11, 0, 0);
        tbl[11] = mk(0, 32'h0,        2'd0, 0, 0, 1, 8'h22, 0, 0);
        tbl[12] = mk(0, 32'h0,        2'd0, 0, 0, 1, 8'h22, 0, 0);
        tbl[13] = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h22, 0, 0);
        tbl[14] = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h33, 0, 0);
        tbl[15] = mk(0, 32'h0,        2'd0, 0, 0, 1, 8'h44, 1, 0);
        tbl[16] = mk(0, 32'h0,        2'd0, 1, 0, 1, 8'h44, 1, 1);
        tbl[17] = mk(0, 32'h0,        2'd0, 0, 0, 0, 8'h00, 0, 1);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].vld, tbl[i].data, tbl[i].len, tbl[i].oacc, tbl[i].stall);
            @(negedge clk);
            chk($sformatf("tbl%0d_vld", i), {31'd0, bus.out_vld_r}, {31'd0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_last", i), {31'd0, bus.out_last_r}, {31'd0, tbl[i].e_last});
            chk($sformatf("tbl%0d_iacc", i), {31'd0, bus.in_accept}, {31'd0, tbl[i].e_iacc});
            if (tbl[i].e_vld)
                chk($sformatf("tbl%0d_data", i), {24'd0, bus.out_r}, {24'd0, tbl[i].e_data});
            step();
        end

        // stall_req held through packet A and two idle cycles.
        drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h000000EE, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_iacc_low", {31'd0, bus.in_accept}, 32'd0);
            step();
        end
        bus.stall_req = 1'b0;
        @(negedge clk);
        chk("stall_release_iacc", {31'd0, bus.in_accept}, 32'd1);
        chk("stall_idle_vld", {31'd0, bus.out_vld_r}, 32'd0);
        step();
        bus.in_vld = 1'b0;
        @(negedge clk);
        chk("stall_next_vld", {31'd0, bus.out_vld_r}, 32'd1);
        chk("stall_next_data", {24'd0, bus.out_r}, 32'hEE);
        step();
        cyc();

        // Reset while beat 22 of a 4-beat packet is presented.
        drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0);
        cyc();
        bus.in_vld = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_vld", {31'd0, bus.out_vld_r}, 32'd0);
        step();
        repeat (4) cyc();
        drive(1'b1, 32'h00006655, 2'd1, 1'b1, 1'b0);
        cyc();
        bus.in_vld = 1'b0;
        @(negedge clk);
        chk("post_rst_b0", {24'd0, bus.out_r}, 32'h55);
        step();
        @(negedge clk);
        chk("post_rst_b1", {24'd0, bus.out_r}, 32'h66);
        chk("post_rst_last", {31'd0, bus.out_last_r}, 32'd1);
        step();
        cyc();

`ifdef STREAM_SER_TX_STATS_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        send_pkt(32'h00332211, 2'd2);
        send_pkt(32'h000000AA, 2'd0);
        send_pkt(32'hD4C3B2A1, 2'd3);
        repeat (6) cyc();
        chk("stats_beats", beats_sent_r, 32'd8);
        chk("stats_pkts", pkts_sent_r, 32'd3);
`else
        send_pkt(32'h00332211, 2'd2);
        repeat (4) cyc();
`endif

        // Random traffic; a request is held until it is taken.
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        took = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.in_vld || took) begin
                bus.in_vld  = ($urandom_range(0, 2) != 0);
                bus.in_data = $urandom;
                bus.in_len  = LW'($urandom_range(0, N - 1));
            end
            bus.out_accept = ($urandom_range(0, 3) != 0);
            bus.stall_req  = ($urandom_range(0, 4) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (6) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_ser_tx.md
Name: stream_ser_tx

Overview:
- Transmitter end of the valid/accept stream protocol. Takes one wide packet of up to N words per handshake and serialises it into W-bit beats with a last flag.
- Sits upstream of the two-entry stream buffers. It drives their input-side valid/data and honours their accept.
- A beat transfers on any cycle where out_vld_r & out_accept is 1 ("out advance"). A packet transfers on any cycle where in_vld & in_accept is 1 ("in advance").

Parameters:
- W, 32, beat data width in bits.
- N, 4, maximum beats per packet (N >= 2).
- LW, $clog2(N), width of the length field. Derived; do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- in_vld  input  1  packet request valid.
- in_data  input  N*W  packet payload. Beat k is bits [k*W +: W]; beat 0 is sent first.
- in_len  input  LW  number of beats minus 1 (0 = 1 beat, N-1 = N beats).
- in_accept  output  1  packet accepted this cycle (combinational).
- out_accept  input  1  downstream accept.
- out_vld_r  output  1  beat valid (registered).
- out_r  output  W  beat data (registered).
- out_last_r  output  1  final beat of the packet (registered).
- stall_req  input  1  while 1, blocks acceptance of new packets.

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: out_vld_r=0, out_last_r=0, state=IDLE, remaining count=0. out_r and the payload shift register are not reset.
- State machine has two states:
  - IDLE: no packet held; out_vld_r=0.
  - SEND: a beat is presented; out_vld_r=1.
- in_accept = ~stall_req & (state==IDLE | (state==SEND & out_last_r & out_accept)). This gives back-to-back packets with no bubble.
- IDLE, in advance:
  - load in_data into the shift register; out_r <= beat 0; remaining <= in_len; out_last_r <= (in_len==0).
  - go to SEND. The first beat is visible the cycle after the in advance (latency 1).
- IDLE, no in advance: hold.
- SEND, no out advance: out_r, out_last_r and the shift register hold stable. out_vld_r must not drop while unaccepted.
- SEND, out advance with remaining != 0:
  - shift by W; out_r <= next beat; remaining <= remaining-1.
  - out_last_r <= (remaining==1).
- SEND, out advance with remaining==0:
  - with in advance in the same cycle: load the new packet exactly as from IDLE and stay in SEND.
  - without in advance: go to IDLE; out_vld_r <= 0; out_last_r <= 0.
- Ignored inputs: in_data and in_len are sampled only on an in advance. in_vld while in_accept=0 has no effect; the requester must hold its request.
- stall_req:
  - does not affect a packet already in flight; the remaining beats drain normally.
  - an in-flight packet is never aborted.
  - it only gates the next in advance.
- Throughput: a packet of L beats occupies exactly L out-advance cycles. With continuous out_accept and in_vld, the output is 100% utilised.
- Reset mid-packet: the packet is dropped. out_vld_r is 0 on the cycle after rst, and no partial tail is emitted afterwards.
- Boundary cases:
  - in_len = N-1 sends all N words.
  - in_len = 0 asserts out_last_r on the first beat.
  - out_accept asserted while out_vld_r=0 is a don't-care.

Optional Feature:
- Macro: STREAM_SER_TX_STATS_EN.
- When defined, adds two outputs:
  - beats_sent_r (32 bits): increments on each out advance.
  - pkts_sent_r (32 bits): increments on each out advance with out_last_r=1.
  - Both reset to 0 and wrap from 2^32-1 to 0.
- When undefined, neither port nor the counter logic exists, and all other behaviour is identical.

Test Plan:
- W=8, N=4, single packet: in_data=32'h44332211, in_len=3, out_accept=1 held → out_r = 11, 22, 33, 44 on 4 consecutive cycles; out_last_r=1 only with 44; IDLE afterwards.
- Back-to-back packets: packet A {in_len=1, data=..BBAA}, then packet B {in_len=0, data=..CC}, out_accept=1 → in_accept=1 on A's last beat; beats AA, BB, CC with no bubble; out_last_r=1 on BB and on CC.
- Backpressure: 4-beat packet with out_accept toggling 1,0,0,1,1,0,1 → each beat is held unchanged through accept-low cycles; exactly 4 advances; data in order 11, 22, 33, 44.
- stall_req=1 during packet A and held 2 cycles after A ends, with in_vld=1 → A completes; in_accept stays 0 until stall_req falls; the next packet's first beat appears one cycle after the in advance.
- rst asserted after beat 1 of a 4-beat packet → out_vld_r=0 the next cycle; no beats 33 or 44 emitted; a new packet then transfers correctly.
- STREAM_SER_TX_STATS_EN defined: send packets of length 3, 1 and 4 → beats_sent_r=8, pkts_sent_r=3.
